// File: rtl/tt_capture.sv
// tt_capture: sequential truth-table reader for an N_IN-input combinational
// network. Steps every input vector onto x, holds it SETTLE_CYCLES+1 cycles,
// samples the network output f_in into tt, then makes a second pass over the
// table to decide positive monotonicity.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a capture (accepted only in IDLE)
//   x          vector driven to the network under evaluation
//   f_in       network output, sampled synchronously
//   busy       capture in progress
//   done       one-cycle pulse when results are final
//   valid      results valid from done until the next accepted start
//   tt         truth table, tt[i] = f(x=i)
//   weight     number of ones in tt
//   monotone   function is positive-monotone
module tt_capture #(
   parameter int N_IN          = 7,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        x,
   input  logic                   f_in,
   output logic                   busy,
   output logic                   done,
   output logic                   valid,
   output logic [(1<<N_IN)-1:0]   tt,
   output logic [N_IN:0]          weight,
   output logic                   monotone
);

   localparam logic [N_IN-1:0] IDX_ONE  = 1;
   localparam logic [N_IN-1:0] IDX_LAST = '1;
   localparam logic [3:0]      SETTLE   = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SWEEP, CHECK, FIN} state_t;

   state_t          state, state_nx;
   logic [N_IN-1:0] idx;
   logic [3:0]      cnt;
   logic            sample;
   logic            last;
   logic            viol;

   // sample on the edge that closes the hold window of the current vector
   assign sample = (state == SWEEP) && (cnt == SETTLE);
   assign last   = (idx == IDX_LAST);

   assign x    = (state == SWEEP) ? idx : '0;
   assign busy = (state == SWEEP) || (state == CHECK);
   assign done = (state == FIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SWEEP;
         SWEEP:   if (sample && last) state_nx = CHECK;
         CHECK:   if (last) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A one at idx with a zero at any single-bit-raised neighbour breaks
   // positive monotonicity; all neighbours are examined in the same cycle.
   always_comb begin
      viol = 1'b0;
      for (int j = 0; j < N_IN; j++) begin
         if (!idx[j] && tt[idx] && !tt[idx | (IDX_ONE << j)]) viol = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         cnt      <= '0;
         tt       <= '0;
         weight   <= '0;
         valid    <= 1'b0;
         monotone <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx      <= '0;
                  cnt      <= '0;
                  tt       <= '0;
                  weight   <= '0;
                  valid    <= 1'b0;
                  monotone <= 1'b0;
               end
            end
            SWEEP: begin
               if (sample) begin
                  tt[idx] <= f_in;
                  weight  <= weight + {{N_IN{1'b0}}, f_in};
                  cnt     <= '0;
                  if (last) begin
                     idx      <= '0;
                     monotone <= 1'b1;
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            CHECK: begin
               if (viol) monotone <= 1'b0;
               if (last) begin
                  idx   <= '0;
                  valid <= 1'b1;
               end else begin
                  idx <= idx + IDX_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
